// File: rtl/mul_seq32_pkg.sv
// Shared constants and state encoding for the sequential 32x32 shift-add multiplier.
package mul_seq32_pkg;

  localparam int WIDTH     = 32;
  localparam int LAST_ITER = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_adder32.sv
// 32-bit carry-lookahead adder: 4-bit groups with group generate/propagate, no carry-in.
module cla_adder32 (
  output logic        cout,
  output logic [31:0] sum,
  input  logic [31:0] a,
  input  logic [31:0] b
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [7:0]  gg;
  logic [7:0]  pg;
  logic [8:0]  gc;

  // NOTE: every variable gets a value at the top of the block, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    pg = '0;
    gc = '0;
    c  = '0;
    for (int gi = 0; gi < 8; gi++) begin
      gg[gi] = g[4*gi+3]
             | (p[4*gi+3] & g[4*gi+2])
             | (p[4*gi+3] & p[4*gi+2] & g[4*gi+1])
             | (p[4*gi+3] & p[4*gi+2] & p[4*gi+1] & g[4*gi]);
      pg[gi] = &p[4*gi +: 4];
    end
    for (int gi = 0; gi < 8; gi++) begin
      gc[gi+1] = gg[gi] | (pg[gi] & gc[gi]);
    end
    // Group carries enter each nibble; bits inside a nibble resolve locally.
    for (int i = 0; i < 32; i++) begin
      if (i % 4 == 0) c[i] = gc[i/4];
      else            c[i] = g[i-1] | (p[i-1] & c[i-1]);
    end
    sum  = p ^ c;
    cout = gc[8];
  end

endmodule

// File: rtl/mul_seq32.sv
// Multi-cycle unsigned 32x32->64 shift-add multiplier; one adder pass per cycle, fixed 32 iterations.
module mul_seq32
  import mul_seq32_pkg::*;
#(
  parameter int WIDTH = mul_seq32_pkg::WIDTH,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;

  assign add_b = acc_lo[0] ? mcand : '0;

  cla_adder32 u_adder (
    .cout (add_cout),
    .sum  (add_sum),
    .a    (acc_hi),
    .b    (add_b)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (count == CNT_W'(LAST_ITER)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      count  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (start) begin
          mcand  <= op_a;
          acc_lo <= op_b;
          acc_hi <= '0;
          count  <= '0;
        end
        // The adder carry becomes the top product bit; the 65-bit value shifts right by one.
        RUN: begin
          {acc_hi, acc_lo} <= {add_cout, add_sum, acc_lo[WIDTH-1:1]};
          count            <= count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign product = {acc_hi, acc_lo};

endmodule

// File: tb/tb_mul_seq32.sv
// Self-checking bench for mul_seq32: vector table, handshake corner cases, random regression.
module tb_mul_seq32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int n_pass  = 0;
  int n_total = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  mul_seq32 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expected product.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) check("spurious_done", {63'd0, done}, 64'd0);
      else                   check("product", product, exp_q.pop_front());
    end
  end

  // Called at a negedge in an IDLE cycle; returns at the negedge of the next IDLE cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    int busy_bad = 0;
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (!busy || done) busy_bad++;
    end
    check("busy_window", 64'(busy_bad), 64'd0);
    @(negedge clk);
    check("done_cycle", {62'd0, busy, done}, 64'd1);
    @(negedge clk);
    check("idle_after", {62'd0, busy, done}, 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1 << $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   done_seen;
    logic [31:0] ra, rb;

    vecs[0] = '{32'd3,         32'd5,         64'h0000_0000_0000_000F};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'd0,         32'hDEAD_BEEF, 64'h0000_0000_0000_0000};
    vecs[3] = '{32'h8000_0000, 32'd2,         64'h0000_0001_0000_0000};
    vecs[4] = '{32'd1,         32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
    vecs[5] = '{32'hFFFF_FFFF, 32'd1,         64'h0000_0000_FFFF_FFFF};
    vecs[6] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};

    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy",    {63'd0, busy}, 64'd0);
    check("reset_done",    {63'd0, done}, 64'd0);
    check("reset_product", product, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].p);

    // Starts during RUN and during DONE are ignored; the next IDLE start is accepted.
    start = 1'b1; op_a = 32'd7; op_b = 32'd9;
    exp_q.push_back(64'd63);
    @(posedge clk); #1; start = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i == 10) begin
        start = 1'b1; op_a = 32'd11; op_b = 32'd13;
        @(posedge clk); #1; start = 1'b0;
      end
    end
    @(negedge clk);
    check("ignore_done_cycle", {62'd0, busy, done}, 64'd1);
    start = 1'b1; op_a = 32'd5; op_b = 32'd5;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("ignore_idle", {62'd0, busy, done}, 64'd0);
    check("product_hold", product, 64'd63);
    run_op(32'd2, 32'd3, 64'd6);

    // Reset at RUN iteration 10 aborts without a done pulse.
    start = 1'b1; op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 1; i <= 10; i++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("abort_busy",    {63'd0, busy}, 64'd0);
    check("abort_product", product, 64'd0);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080);

    // Reset and start in the same cycle: reset wins.
    rst = 1'b1; start = 1'b1; op_a = 32'd3; op_b = 32'd3;
    @(posedge clk); #1; rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_busy",    {63'd0, busy}, 64'd0);
    check("rst_start_product", product, 64'd0);

    for (int n = 0; n < 1000; n++) begin
      ra = pick_operand();
      rb = pick_operand();
      run_op(ra, rb, {32'd0, ra} * {32'd0, rb});
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
